// File: rtl/br_encode_pkg.sv
// Shared branch-encoding definitions: kind codes, opcodes and offset field selectors.
package br_encode_pkg;

  typedef enum logic [2:0] {
    BRK_B    = 3'd0,
    BRK_BL   = 3'd1,
    BRK_BEQ  = 3'd2,
    BRK_BNE  = 3'd3,
    BRK_BLT  = 3'd4,
    BRK_BGE  = 3'd5,
    BRK_BLTU = 3'd6,
    BRK_BGEU = 3'd7
  } br_kind_e;

  // Same selector codes the decode side uses for offset extraction.
  typedef enum logic {
    OFFS_16_SEXT = 1'b0,
    OFFS_26_SEXT = 1'b1
  } offs_fmt_e;

  localparam logic [5:0] OP_B   = 6'b010100;
  localparam logic [5:0] OP_BL  = 6'b010101;
  localparam logic [5:0] OP_BEQ = 6'b010110;

  function automatic logic [5:0] br_opcode(input br_kind_e k);
    case (k)
      BRK_B:   br_opcode = OP_B;
      BRK_BL:  br_opcode = OP_BL;
      default: br_opcode = OP_BEQ + {3'b000, k} - 6'd2;
    endcase
  endfunction

  function automatic offs_fmt_e br_fmt(input br_kind_e k);
    br_fmt = (k == BRK_B || k == BRK_BL) ? OFFS_26_SEXT : OFFS_16_SEXT;
  endfunction

endpackage

// File: rtl/br_encode_if.sv
// Request/response bundle for the branch encoder.
interface br_encode_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [31:0] in_pc;
  logic [31:0] in_target;
  logic [4:0]  in_rj;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err_align;
  logic        out_err_range;

  modport master (
    output in_valid, in_kind, in_pc, in_target, in_rj, in_rd, out_ready,
    input  in_ready, out_valid, out_instr, out_err_align, out_err_range
  );

  modport slave (
    input  in_valid, in_kind, in_pc, in_target, in_rj, in_rd, out_ready,
    output in_ready, out_valid, out_instr, out_err_align, out_err_range
  );
endinterface

// File: rtl/br_offs_pack.sv
// Packs a word offset into the I16 or I26 branch field layout and flags out-of-range offsets.
module br_offs_pack
  import br_encode_pkg::*;
(
  input  logic [29:0] woff,
  input  offs_fmt_e   fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rj,
  input  logic [4:0]  rd,
  output logic [31:0] instr,
  output logic        err_range
);

  always_comb begin
    instr     = {opcode, woff[15:0], 10'b0};
    err_range = 1'b0;
    if (fmt == OFFS_26_SEXT) begin
      err_range  = woff[29:25] != {5{woff[25]}};
      instr[9:0] = woff[25:16];
    end else begin
      err_range  = woff[29:15] != {15{woff[15]}};
      instr[9:5] = rj;
      instr[4:0] = rd;
    end
  end

endmodule

// File: rtl/br_encode.sv
// Two-stage valid/ready pipeline producing a LoongArch branch instruction word.
module br_encode
  import br_encode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  br_encode_if.slave  bus
);

  logic        s1_valid;
  br_kind_e    s1_kind;
  logic [4:0]  s1_rj;
  logic [4:0]  s1_rd;
  logic [31:0] s1_diff;

  logic        s2_valid;
  logic [31:0] s2_instr;
  logic        s2_err_align;
  logic        s2_err_range;

  logic        s2_ready;
  logic        in_ready;
  logic [31:0] pack_instr;
  logic        pack_err_range;
  logic        err_align;

  assign s2_ready  = !s2_valid || bus.out_ready;
  assign in_ready  = !s1_valid || s2_ready;
  assign err_align = s1_diff[1:0] != 2'b00;

  br_offs_pack u_pack (
    .woff      (s1_diff[31:2]),
    .fmt       (br_fmt(s1_kind)),
    .opcode    (br_opcode(s1_kind)),
    .rj        (s1_rj),
    .rd        (s1_rd),
    .instr     (pack_instr),
    .err_range (pack_err_range)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_kind  <= BRK_B;
      s1_rj    <= '0;
      s1_rd    <= '0;
      s1_diff  <= '0;
    end else if (in_ready) begin
      s1_valid <= bus.in_valid;
      s1_kind  <= br_kind_e'(bus.in_kind);
      s1_rj    <= bus.in_rj;
      s1_rd    <= bus.in_rd;
      s1_diff  <= bus.in_target - bus.in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid     <= 1'b0;
      s2_instr     <= '0;
      s2_err_align <= 1'b0;
      s2_err_range <= 1'b0;
    end else if (s2_ready) begin
      s2_valid     <= s1_valid;
      s2_instr     <= (err_align || pack_err_range) ? '0 : pack_instr;
      s2_err_align <= err_align;
      s2_err_range <= pack_err_range;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = s2_valid;
  assign bus.out_instr     = s2_instr;
  assign bus.out_err_align = s2_err_align;
  assign bus.out_err_range = s2_err_range;

endmodule

// File: tb/tb_br_encode.sv
// Scoreboard bench for br_encode: directed requests, backpressure and mid-flight reset.
module tb_br_encode;

  typedef struct {
    logic [31:0] instr;
    logic        ea;
    logic        er;
    int          acc;
    logic        chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  logic        held_v = 1'b0;
  logic [31:0] held_instr;
  logic        held_ea;
  logic        held_er;
  logic        saw_in_ready_low = 1'b0;
  logic        chk_lat = 1'b0;

  br_encode_if bus ();

  br_encode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Output side: consume transfers, and check hold-stability during stalls.
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (!bus.in_ready) saw_in_ready_low = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        held_v = 1'b0;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got instr 0x%08h with empty scoreboard", bus.out_instr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("instr", bus.out_instr, e.instr);
          check("err_align", {31'b0, bus.out_err_align}, {31'b0, e.ea});
          check("err_range", {31'b0, bus.out_err_range}, {31'b0, e.er});
          if (e.chk_lat) check("latency", cyc + 1 - e.acc, 32'd2);
        end
      end else if (bus.out_valid && !bus.out_ready) begin
        if (held_v) begin
          check("stall_instr", bus.out_instr, held_instr);
          check("stall_flags", {30'b0, bus.out_err_align, bus.out_err_range}, {30'b0, held_ea, held_er});
        end
        held_v     = 1'b1;
        held_instr = bus.out_instr;
        held_ea    = bus.out_err_align;
        held_er    = bus.out_err_range;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 right after the accepting edge.
  task automatic send(input logic [2:0] k, input logic [31:0] pc, input logic [31:0] tgt,
                      input logic [4:0] rj, input logic [4:0] rd,
                      input logic [31:0] ei, input logic ea, input logic er);
    exp_t e;
    int   t;
    bus.in_valid  = 1'b1;
    bus.in_kind   = k;
    bus.in_pc     = pc;
    bus.in_target = tgt;
    bus.in_rj     = rj;
    bus.in_rd     = rd;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      t++;
      if (t > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", t);
        break;
      end
    end
    e.instr   = ei;
    e.ea      = ea;
    e.er      = er;
    e.acc     = cyc + 1;
    e.chk_lat = chk_lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_left", sb.size(), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_kind   = '0;
    bus.in_pc     = '0;
    bus.in_target = '0;
    bus.in_rj     = '0;
    bus.in_rd     = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_flags", {30'b0, bus.out_err_align, bus.out_err_range}, 32'd0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // Functional vectors, one at a time with latency checks.
    chk_lat = 1'b1;
    send(3'd0, 32'h1C000000, 32'h1C000010, 5'd0, 5'd0, 32'h50001000, 1'b0, 1'b0); idle(3);
    send(3'd1, 32'h1C000100, 32'h1C000000, 5'd0, 5'd0, 32'h57FF03FF, 1'b0, 1'b0); idle(3);
    send(3'd2, 32'h1C000000, 32'h1C000008, 5'd4, 5'd5, 32'h58000885, 1'b0, 1'b0); idle(3);
    chk_lat = 1'b0;
    send(3'd2, 32'h1C000000, 32'h1C020000, 5'd4, 5'd5, 32'h00000000, 1'b0, 1'b1);
    send(3'd0, 32'h1C000000, 32'h1C000002, 5'd0, 5'd0, 32'h00000000, 1'b1, 1'b0);
    send(3'd2, 32'h1C000000, 32'h1C020002, 5'd4, 5'd5, 32'h00000000, 1'b1, 1'b1);
    send(3'd2, 32'h1C000000, 32'h1C01FFFC, 5'd0, 5'd0, 32'h59FFFC00, 1'b0, 1'b0);
    send(3'd0, 32'h1C000000, 32'h14000000, 5'd0, 5'd0, 32'h50000200, 1'b0, 1'b0);
    send(3'd7, 32'h00000000, 32'hFFFFFFFC, 5'd31, 5'd1, 32'h6FFFFFE1, 1'b0, 1'b0);
    send(3'd1, 32'hFFFFFFFC, 32'h00000000, 5'd0, 5'd0, 32'h54000400, 1'b0, 1'b0);
    idle(1);
    drain();

    // Backpressure: 4 back-to-back with out_ready low for 3 cycles mid-stream.
    saw_in_ready_low = 1'b0;
    fork
      begin
        send(3'd0, 32'h1C000000, 32'h1C000010, 5'd0, 5'd0, 32'h50001000, 1'b0, 1'b0);
        send(3'd3, 32'h1C000000, 32'h1C000004, 5'd1, 5'd2, 32'h5C000422, 1'b0, 1'b0);
        send(3'd4, 32'h1C000010, 32'h1C000000, 5'd3, 5'd4, 32'h63FFF064, 1'b0, 1'b0);
        send(3'd1, 32'h1C000000, 32'h1C000004, 5'd0, 5'd0, 32'h54000400, 1'b0, 1'b0);
        idle(1);
      end
      begin
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_in_ready_dropped", {31'b0, saw_in_ready_low}, 32'd1);

    // Reset with two requests in flight: nothing may emerge afterwards.
    bus.out_ready = 1'b0;
    send(3'd0, 32'h1C000000, 32'h1C000010, 5'd0, 5'd0, 32'h50001000, 1'b0, 1'b0);
    send(3'd2, 32'h1C000000, 32'h1C000008, 5'd4, 5'd5, 32'h58000885, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    idle(6);
    send(3'd2, 32'h1C000000, 32'h1C000008, 5'd4, 5'd5, 32'h58000885, 1'b0, 1'b0);
    idle(1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/br_encode.md
Name: br_encode

Overview:
- Inverse of the decode-side offset extraction. Takes a branch kind, PC, target address and register fields, and produces a 32-bit LoongArch branch instruction word.
- The signed word offset is split into the I16 or I26 field layout.
- Two-stage valid/ready pipeline with alignment and range checking.
- Used by the trampoline/patch generator and the self-test instruction stream builder ahead of IF.

Parameters:
- none; all widths fixed (PC/target 32, instruction 32).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&&in_ready at posedge clk
- in_kind  in  3  branch kind: 0 B, 1 BL, 2 BEQ, 3 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU
- in_pc  in  32  address of the branch instruction
- in_target  in  32  branch target address
- in_rj  in  5  rj field (conditional kinds only)
- in_rd  in  5  rd field (conditional kinds only)
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_instr  out  32  encoded instruction; 32'h0 when any error flag is set
- out_err_align  out  1  target-pc not a multiple of 4
- out_err_range  out  1  offset does not fit the field

Behaviour:
- Reset: S1/S2 valid cleared; out_valid=0, out_instr=0, out_err_align=0, out_err_range=0. in_ready=1 in the cycle after reset.
- Reset mid-operation discards all in-flight requests; nothing is emitted for them.
- Pipeline:
  - in_ready = !s1_valid || s2_ready.
  - s2_ready = !s2_valid || out_ready.
  - Each stage register loads only when its downstream ready is high; otherwise it holds.
- Latency and throughput:
  - Accept at edge N gives out_valid at edge N+2 if out_ready stayed high.
  - One result per cycle sustained.
  - Stall (out_ready=0): out_* stay stable; no result is lost or duplicated.
- S1 (registered at accept):
  - Latch kind, rj, rd.
  - diff = in_target - in_pc, 32-bit two's-complement; wrap-around is intentional (0x0 - 0xFFFFFFFC = +4).
- S2:
  - err_align = diff[1:0] != 0.
  - Word offset w = diff[31:2] (arithmetic).
  - I26 kinds (B, BL): err_range when diff[31:27] is not all equal to diff[27]. Legal byte range -2^27 .. 2^27-4.
  - I16 kinds (conditional): err_range when diff[31:17] is not all equal to diff[17]. Legal byte range -2^17 .. 2^17-4.
  - err_align takes no precedence: both flags may be set together.
- Packing, when no error:
  - B: [31:26]=6'b010100, [25:10]=w[15:0], [9:0]=w[25:16].
  - BL: opcode 6'b010101, same field layout as B.
  - Conditional kinds: opcode 6'b010110+kind-2 (BEQ 010110 .. BGEU 011011), [25:10]=w[15:0], [9:5]=rj, [4:0]=rd.
  - rj/rd are ignored for B/BL.
- Error: out_instr=0, with flags as computed.
- Flags are valid only when out_valid=1. They are held stable with out_instr during a stall.

Decomposition:
- Shared defines header: branch-kind codes (`BRK_B .. `BRK_BGEU), branch opcode constants, and the existing `OFFS_26_SEXT/`OFFS_16_SEXT selector codes.
  - The S2 field-format select reuses the `OFFS_*` selector codes so encode and decode agree.
- One combinational sub-module, br_offs_pack.
  - Inputs: word offset, format select, opcode, rj, rd.
  - Outputs: instruction word and range error.
  - Keeps the field layout in one place.
- Pipeline/handshake logic stays in br_encode.

Test Plan:
- B forward: kind=0, pc=0x1C000000, target=0x1C000010 -> out_instr=0x50001000, no errors, out_valid 2 cycles after accept.
- BL backward: kind=1, pc=0x1C000100, target=0x1C000000 -> out_instr=0x57FF03FF.
- BEQ: kind=2, pc=0x1C000000, target=0x1C000008, rj=4, rd=5 -> out_instr=0x58000885.
- Errors:
  - BEQ target=pc+0x20000 -> err_range=1, out_instr=0.
  - B target=pc+2 -> err_align=1.
  - BEQ target=pc+0x20002 -> both flags set.
  - BEQ target=pc+0x1FFFC and B target=pc-0x8000000 -> both legal, no flags.
- Backpressure: 4 back-to-back requests with out_ready held low 3 cycles mid-stream -> in_ready drops, outputs hold, all 4 results emerge in order exactly once.
- Reset: assert rst with 2 requests in flight -> out_valid=0 next cycle, in_ready=1, no stale result emitted.
